// File: rtl/per2axi_res_channel_pipe.sv
// Peripheral response pipe: round-robin merge of AXI R/B, per-ID 32-bit lane FIFOs, registered response.
// Optional per-core xresp outputs are enabled by defining PER2AXI_XRESP_EN.
module per2axi_res_channel_pipe #(
  parameter int NB_CORES       = 4,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 3,
  parameter int AXI_USER_WIDTH = 6,
  parameter int NB_OUTSTANDING = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output logic [NB_CORES-1:0]       axi_xresp_slverr_o,
  output logic [NB_CORES-1:0]       axi_xresp_valid_o,
  input  logic                      axi_master_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
  input  logic [1:0]                axi_master_r_resp_i,
  input  logic                      axi_master_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
  output logic                      axi_master_r_ready_o,
  input  logic                      axi_master_b_valid_i,
  input  logic [1:0]                axi_master_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
  output logic                      axi_master_b_ready_o,
  input  logic                      trans_req_i,
  input  logic                      trans_we_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  output logic                      lane_fifo_ovf_o,
  output logic                      lane_fifo_udf_o
);

  localparam int LANES = AXI_DATA_WIDTH / 32;
  localparam int LW    = $clog2(LANES);
  localparam int LWW   = (LW > 0) ? LW : 1;
  localparam int PW    = (NB_OUTSTANDING > 1) ? $clog2(NB_OUTSTANDING) : 1;
  localparam int DEPTH = 1 << PW;
  localparam int CW    = $clog2(NB_OUTSTANDING + 1);

  function automatic logic [PER_ID_WIDTH-1:0] id_onehot(input logic [AXI_ID_WIDTH-1:0] id);
    logic [PER_ID_WIDTH-1:0] v;
    for (int p = 0; p < PER_ID_WIDTH; p++) v[p] = (int'(id) == p);
    return v;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == NB_OUTSTANDING - 1) ? '0 : p + PW'(1);
  endfunction

  logic                w_both;
  logic                w_gnt_r;
  logic                w_gnt_b;
  logic                r_last_b;
  logic [NB_CORES-1:0] w_rid_vec;
  logic [NB_CORES-1:0] w_push_vec;
  logic [LWW-1:0]      w_lane;
  logic                w_ovf_evt;
  logic                w_udf_evt;
  logic [31:0]         w_rdata_sel;
  logic                r_valid;
  logic                r_opc;
  logic [PER_ID_WIDTH-1:0] r_id;
  logic [31:0]         r_rdata;
  logic                r_ovf;
  logic                r_udf;

  assign w_both = axi_master_r_valid_i & axi_master_b_valid_i;

  // Grant: lone valid wins; on contention serve the channel not served last time
  always_comb begin
    w_gnt_r = 1'b0;
    w_gnt_b = 1'b0;
    if (rst_i) begin
      w_gnt_r = 1'b0;
      w_gnt_b = 1'b0;
    end else if (w_both) begin
      w_gnt_r = r_last_b;
      w_gnt_b = ~r_last_b;
    end else begin
      w_gnt_r = axi_master_r_valid_i;
      w_gnt_b = axi_master_b_valid_i;
    end
  end

  assign axi_master_r_ready_o = w_gnt_r;
  assign axi_master_b_ready_o = w_gnt_b;

  // Round-robin pointer; reset value makes R the first contended winner
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_b <= 1'b1;
    end else if (w_both) begin
      r_last_b <= w_gnt_b;
    end else begin
      r_last_b <= r_last_b;
    end
  end

  // Per-ID decode of the R id and of read pushes
  always_comb begin
    w_rid_vec  = '0;
    w_push_vec = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      w_rid_vec[i]  = (int'(axi_master_r_id_i) == i);
      w_push_vec[i] = trans_req_i & ~trans_we_i & (int'(trans_id_i) == i);
    end
  end

  generate
    if (LW > 0) begin : g_lane_fifo
      logic [LW-1:0]       r_mem  [NB_CORES][DEPTH];
      logic [PW-1:0]       r_wptr [NB_CORES];
      logic [PW-1:0]       r_rptr [NB_CORES];
      logic [CW-1:0]       r_cnt  [NB_CORES];
      logic [NB_CORES-1:0] w_full;
      logic [NB_CORES-1:0] w_empty;
      logic [NB_CORES-1:0] w_pop;
      logic [NB_CORES-1:0] w_push_ok;
      logic [LW-1:0]       w_push_lane;

      assign w_push_lane = trans_add_i[LW+1:2];

      // Pop only on the last beat; a pop frees room for a same-cycle push to a full FIFO
      always_comb begin
        w_full    = '0;
        w_empty   = '0;
        w_pop     = '0;
        w_push_ok = '0;
        for (int i = 0; i < NB_CORES; i++) begin
          w_full[i]    = (int'(r_cnt[i]) == NB_OUTSTANDING);
          w_empty[i]   = (r_cnt[i] == '0);
          w_pop[i]     = w_gnt_r & axi_master_r_last_i & w_rid_vec[i] & ~w_empty[i];
          w_push_ok[i] = w_push_vec[i] & (~w_full[i] | w_pop[i]);
        end
      end

      // Head lane of the responding ID; lane 0 when that FIFO is empty
      always_comb begin
        w_lane = '0;
        for (int i = 0; i < NB_CORES; i++) begin
          w_lane = (w_rid_vec[i] & ~w_empty[i]) ? r_mem[i][r_rptr[i]] : w_lane;
        end
        w_udf_evt = w_gnt_r & ~|(w_rid_vec & ~w_empty);
        w_ovf_evt = |(w_push_vec & ~w_push_ok);
      end

      // Lane storage; stale entries are harmless because pointers reset
      always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB_CORES; i++) begin
          if (w_push_ok[i]) begin
            r_mem[i][r_wptr[i]] <= w_push_lane;
          end else begin
            r_mem[i][r_wptr[i]] <= r_mem[i][r_wptr[i]];
          end
        end
      end

      // FIFO pointers and occupancy
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < NB_CORES; i++) begin
            r_wptr[i] <= '0;
            r_rptr[i] <= '0;
            r_cnt[i]  <= '0;
          end
        end else begin
          for (int i = 0; i < NB_CORES; i++) begin
            r_wptr[i] <= w_push_ok[i] ? ptr_inc(r_wptr[i]) : r_wptr[i];
            r_rptr[i] <= w_pop[i] ? ptr_inc(r_rptr[i]) : r_rptr[i];
            case ({w_push_ok[i], w_pop[i]})
              2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
              2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
              default: r_cnt[i] <= r_cnt[i];
            endcase
          end
        end
      end
    end else begin : g_single_lane
      assign w_lane    = '0;
      assign w_ovf_evt = 1'b0;
      assign w_udf_evt = 1'b0;
    end
  endgenerate

  // 32-bit lane select from the R data bus
  always_comb begin
    w_rdata_sel = axi_master_r_data_i[31:0];
    for (int l = 1; l < LANES; l++) begin
      w_rdata_sel = (int'(w_lane) == l) ? axi_master_r_data_i[32*l +: 32] : w_rdata_sel;
    end
  end

  // Sticky FIFO error flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_ovf_evt;
      r_udf <= r_udf | w_udf_evt;
    end
  end

  // Registered peripheral response: one pulse per handshake, all-zero otherwise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_opc   <= 1'b0;
      r_id    <= '0;
      r_rdata <= 32'h0000_0000;
    end else if (w_gnt_r) begin
      r_valid <= 1'b1;
      r_opc   <= axi_master_r_resp_i[1];
      r_id    <= id_onehot(axi_master_r_id_i);
      r_rdata <= w_rdata_sel;
    end else if (w_gnt_b) begin
      r_valid <= 1'b1;
      r_opc   <= axi_master_b_resp_i[1];
      r_id    <= id_onehot(axi_master_b_id_i);
      r_rdata <= {31'b0, ~axi_master_b_resp_i[0]};
    end else begin
      r_valid <= 1'b0;
      r_opc   <= 1'b0;
      r_id    <= '0;
      r_rdata <= 32'h0000_0000;
    end
  end

  assign per_slave_r_valid_o = r_valid;
  assign per_slave_r_opc_o   = r_opc;
  assign per_slave_r_id_o    = r_id;
  assign per_slave_r_rdata_o = r_rdata;
  assign lane_fifo_ovf_o     = r_ovf;
  assign lane_fifo_udf_o     = r_udf;

`ifdef PER2AXI_XRESP_EN
  logic [NB_CORES-1:0] w_bid_vec;
  logic [NB_CORES-1:0] r_xresp;
  logic                w_unused;

  always_comb begin
    w_bid_vec = '0;
    for (int i = 0; i < NB_CORES; i++) w_bid_vec[i] = (int'(axi_master_b_id_i) == i);
  end

  // SLVERR marker for the responding core, aligned with the response pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_xresp <= '0;
    end else if (w_gnt_r && (axi_master_r_resp_i == 2'b10)) begin
      r_xresp <= w_rid_vec;
    end else if (w_gnt_b && (axi_master_b_resp_i == 2'b10)) begin
      r_xresp <= w_bid_vec;
    end else begin
      r_xresp <= '0;
    end
  end

  assign axi_xresp_slverr_o = r_xresp;
  assign axi_xresp_valid_o  = r_xresp;
  assign w_unused = ^{axi_master_r_user_i, axi_master_b_user_i, trans_add_i, w_push_vec};
`else
  logic w_unused;
  assign axi_xresp_slverr_o = '0;
  assign axi_xresp_valid_o  = '0;
  assign w_unused = ^{axi_master_r_user_i, axi_master_b_user_i, trans_add_i,
                      axi_master_r_resp_i[0], w_push_vec};
`endif

endmodule

// File: tb/tb_per2axi_res_channel_pipe.sv
// Self-checking bench for per2axi_res_channel_pipe (128-bit data): directed cases plus random traffic
// checked against a queue-based reference model.
module tb_per2axi_res_channel_pipe;
  localparam int NB_CORES       = 4;
  localparam int PER_ID_WIDTH   = 5;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 128;
  localparam int AXI_ID_WIDTH   = 3;
  localparam int AXI_USER_WIDTH = 6;
  localparam int NB_OUTSTANDING = 2;
  localparam int LW             = 2;

  logic clk, rst_i;
  logic per_slave_r_valid_o, per_slave_r_opc_o;
  logic [PER_ID_WIDTH-1:0] per_slave_r_id_o;
  logic [31:0] per_slave_r_rdata_o;
  logic [NB_CORES-1:0] axi_xresp_slverr_o, axi_xresp_valid_o;
  logic r_valid, r_last, r_ready, b_valid, b_ready;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0] r_resp, b_resp;
  logic [AXI_ID_WIDTH-1:0] r_id, b_id, t_id;
  logic [AXI_USER_WIDTH-1:0] r_user, b_user;
  logic t_req, t_we;
  logic [AXI_ADDR_WIDTH-1:0] t_add;
  logic ovf, udf;

  int n_checks, n_errors;
  int unsigned lq [NB_CORES][$];
  bit m_last_b, m_ovf, m_udf, obs_rr;

  per2axi_res_channel_pipe #(
    .NB_CORES(NB_CORES), .PER_ID_WIDTH(PER_ID_WIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH), .AXI_ID_WIDTH(AXI_ID_WIDTH),
    .AXI_USER_WIDTH(AXI_USER_WIDTH), .NB_OUTSTANDING(NB_OUTSTANDING)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .per_slave_r_valid_o(per_slave_r_valid_o), .per_slave_r_opc_o(per_slave_r_opc_o),
    .per_slave_r_id_o(per_slave_r_id_o), .per_slave_r_rdata_o(per_slave_r_rdata_o),
    .axi_xresp_slverr_o(axi_xresp_slverr_o), .axi_xresp_valid_o(axi_xresp_valid_o),
    .axi_master_r_valid_i(r_valid), .axi_master_r_data_i(r_data), .axi_master_r_resp_i(r_resp),
    .axi_master_r_last_i(r_last), .axi_master_r_id_i(r_id), .axi_master_r_user_i(r_user),
    .axi_master_r_ready_o(r_ready),
    .axi_master_b_valid_i(b_valid), .axi_master_b_resp_i(b_resp), .axi_master_b_id_i(b_id),
    .axi_master_b_user_i(b_user), .axi_master_b_ready_o(b_ready),
    .trans_req_i(t_req), .trans_we_i(t_we), .trans_id_i(t_id), .trans_add_i(t_add),
    .lane_fifo_ovf_o(ovf), .lane_fifo_udf_o(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_idle();
    r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0; r_id = '0; r_user = '0;
    b_valid = 1'b0; b_resp = 2'b00; b_id = '0; b_user = '0;
    t_req = 1'b0; t_we = 1'b0; t_id = '0; t_add = '0;
  endtask

  // One clock: reference model predicts from current inputs, then DUT is compared
  task automatic cycle();
    bit gr, gb;
    int unsigned lane;
    int id;
    logic e_valid, e_opc;
    logic [PER_ID_WIDTH-1:0] e_id;
    logic [31:0] e_rdata;
    logic [NB_CORES-1:0] e_x;
    gr = 1'b0; gb = 1'b0; e_valid = 1'b0; e_opc = 1'b0; e_id = '0; e_rdata = '0; e_x = '0;
    if (rst_i) begin
      for (int i = 0; i < NB_CORES; i++) lq[i].delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_last_b = 1'b1;
    end else begin
      if (r_valid && b_valid) begin
        gr = m_last_b; gb = !m_last_b; m_last_b = gb;
      end else begin
        gr = r_valid; gb = b_valid;
      end
      if (gr) begin
        id = int'(r_id);
        if (lq[id].size() == 0) begin
          lane = 0; m_udf = 1'b1;
        end else begin
          lane = lq[id][0];
          if (r_last) void'(lq[id].pop_front());
        end
        e_valid = 1'b1; e_opc = r_resp[1]; e_id = PER_ID_WIDTH'(1 << id);
        e_rdata = r_data[32*lane +: 32];
        if (r_resp == 2'b10) e_x = NB_CORES'(1 << id);
      end else if (gb) begin
        id = int'(b_id);
        e_valid = 1'b1; e_opc = b_resp[1]; e_id = PER_ID_WIDTH'(1 << id);
        e_rdata = {31'b0, ~b_resp[0]};
        if (b_resp == 2'b10) e_x = NB_CORES'(1 << id);
      end
      if (t_req && !t_we) begin
        if (lq[int'(t_id)].size() < NB_OUTSTANDING) lq[int'(t_id)].push_back(int'(t_add[LW+1:2]));
        else m_ovf = 1'b1;
      end
    end
`ifndef PER2AXI_XRESP_EN
    e_x = '0;
`endif
    #1;
    obs_rr = r_ready;
    check_val("r_ready", r_ready, gr);
    check_val("b_ready", b_ready, gb);
    @(posedge clk);
    #1;
    check_val("valid", per_slave_r_valid_o, e_valid);
    check_val("id", per_slave_r_id_o, e_id);
    check_val("rdata", per_slave_r_rdata_o, e_rdata);
    check_val("opc", per_slave_r_opc_o, e_opc);
    check_val("ovf", ovf, m_ovf);
    check_val("udf", udf, m_udf);
    check_val("xresp_slverr", axi_xresp_slverr_o, e_x);
    check_val("xresp_valid", axi_xresp_valid_o, e_x);
  endtask

  task automatic push_rd(input int id, input logic [31:0] add);
    drive_idle(); t_req = 1'b1; t_we = 1'b0; t_id = AXI_ID_WIDTH'(id); t_add = add;
    cycle();
  endtask

  task automatic r_beat(input int id, input logic [127:0] data);
    drive_idle(); r_valid = 1'b1; r_id = AXI_ID_WIDTH'(id); r_last = 1'b1; r_data = data;
    cycle();
  endtask

  initial begin
    logic [3:0] seq;
    int pulses;
    n_checks = 0; n_errors = 0; m_last_b = 1'b1; m_ovf = 1'b0; m_udf = 1'b0;
    drive_idle();
    rst_i = 1'b1;
    repeat (3) cycle();
    check_val("rst_valid", per_slave_r_valid_o, 1'b0);
    rst_i = 1'b0;

    push_rd(1, 32'h0000_0008);
    r_beat(1, {32'h4444_4444, 32'hCAFE_F00D, 32'h2222_2222, 32'h1111_1111});
    check_val("rd128_rdata", per_slave_r_rdata_o, 32'hCAFE_F00D);
    check_val("rd128_id", per_slave_r_id_o, 5'b00010);
    check_val("rd128_valid", per_slave_r_valid_o, 1'b1);

    push_rd(0, 32'h0000_0004);
    push_rd(0, 32'h0000_0000);
    r_beat(0, {32'h0, 32'h0, 32'hBBBB_0001, 32'hAAAA_0000});
    check_val("outst_first", per_slave_r_rdata_o, 32'hBBBB_0001);
    r_beat(0, {32'h0, 32'h0, 32'hBBBB_0001, 32'hAAAA_0000});
    check_val("outst_second", per_slave_r_rdata_o, 32'hAAAA_0000);

    push_rd(0, 32'h0000_000C);
    push_rd(0, 32'h0000_0004);
    seq = 4'b0000; pulses = 0;
    for (int k = 0; k < 4; k++) begin
      drive_idle();
      r_valid = 1'b1; r_id = 3'd0; r_last = 1'b1;
      r_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_valid = 1'b1; b_id = 3'd2; b_resp = 2'b00;
      cycle();
      seq = {seq[2:0], obs_rr};
      pulses += int'(per_slave_r_valid_o);
    end
    check_val("arb_seq", seq, 4'b1010);
    check_val("arb_pulses", pulses, 4);

    push_rd(2, 32'h0000_0000);
    push_rd(2, 32'h0000_0004);
    push_rd(2, 32'h0000_0008);
    check_val("ovf_set", ovf, 1'b1);
    drive_idle(); cycle();
    check_val("ovf_sticky", ovf, 1'b1);
    r_beat(2, {$urandom(), $urandom(), $urandom(), $urandom()});
    r_beat(2, {$urandom(), $urandom(), $urandom(), $urandom()});

    r_beat(3, {32'h9, 32'h8, 32'h7, 32'h5A5A_0003});
    check_val("udf_set", udf, 1'b1);
    check_val("udf_lane0", per_slave_r_rdata_o, 32'h5A5A_0003);

    drive_idle(); b_valid = 1'b1; b_id = 3'd3; b_resp = 2'b10; cycle();
    check_val("werr_rdata", per_slave_r_rdata_o, 32'h1);
    check_val("werr_opc", per_slave_r_opc_o, 1'b1);
`ifdef PER2AXI_XRESP_EN
    check_val("werr_slverr", axi_xresp_slverr_o, 4'b1000);
`else
    check_val("werr_slverr", axi_xresp_slverr_o, 4'b0000);
`endif

    push_rd(1, 32'h0000_0004);
    push_rd(1, 32'h0000_0008);
    drive_idle(); r_valid = 1'b1; r_id = 3'd1; r_last = 1'b1; rst_i = 1'b1;
    cycle();
    check_val("mrst_valid", per_slave_r_valid_o, 1'b0);
    check_val("mrst_ovf", ovf, 1'b0);
    check_val("mrst_udf", udf, 1'b0);
    rst_i = 1'b0;
    r_beat(1, {32'h3, 32'h2, 32'h1, 32'hD00D_0000});
    check_val("mrst_empty", per_slave_r_rdata_o, 32'hD00D_0000);

    for (int k = 0; k < 400; k++) begin
      drive_idle();
      r_valid = ($urandom_range(0, 1) == 1);
      r_id = AXI_ID_WIDTH'($urandom_range(0, NB_CORES - 1));
      r_last = ($urandom_range(0, 3) != 0);
      r_resp = 2'($urandom_range(0, 3));
      r_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_valid = ($urandom_range(0, 1) == 1);
      b_id = AXI_ID_WIDTH'($urandom_range(0, NB_CORES - 1));
      b_resp = 2'($urandom_range(0, 3));
      t_req = ($urandom_range(0, 4) < 2);
      t_we = ($urandom_range(0, 3) == 0);
      t_id = AXI_ID_WIDTH'($urandom_range(0, NB_CORES - 1));
      t_add = $urandom();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/per2axi_res_channel_pipe.md
Name: per2axi_res_channel_pipe

Overview:
- Parametrised successor to the peripheral-to-AXI response channel.
- Collects AXI R and B responses and arbitrates them round-robin, so a steady stream on one channel cannot starve the other.
- Selects the correct 32-bit lane for any AXI_DATA_WIDTH, using per-ID lane FIFOs. These FIFOs support several outstanding reads per ID.
- Registers the peripheral response; sits between the AXI master port and the peripheral interconnect response path.

Parameters:
- NB_CORES, 4, number of requesting IDs; must be <= PER_ID_WIDTH.
- PER_ID_WIDTH, 5, width of the one-hot peripheral response ID.
- AXI_ADDR_WIDTH, 32, transaction address width.
- AXI_DATA_WIDTH, 64, AXI data width; power of two, 32 to 512.
- AXI_ID_WIDTH, 3, AXI ID width; value must be < NB_CORES.
- AXI_USER_WIDTH, 6, AXI user width; user input is unused.
- NB_OUTSTANDING, 2, per-ID lane FIFO depth; power of two, >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- per_slave_r_valid_o  out  1  response valid; one-cycle pulse per response.
- per_slave_r_opc_o  out  1  1 = error response (resp[1] set).
- per_slave_r_id_o  out  PER_ID_WIDTH  one-hot ID of the response.
- per_slave_r_rdata_o  out  32  read data, or write status.
- axi_xresp_slverr_o  out  NB_CORES  SLVERR indication, one-hot.
- axi_xresp_valid_o  out  NB_CORES  xresp valid, one-hot.
- axi_master_r_valid_i / r_data_i[AXI_DATA_WIDTH] / r_resp_i[2] / r_last_i / r_id_i[AXI_ID_WIDTH] / r_user_i[AXI_USER_WIDTH]  in  AXI R channel.
- axi_master_r_ready_o  out  1  R ready.
- axi_master_b_valid_i / b_resp_i[2] / b_id_i / b_user_i  in  AXI B channel.
- axi_master_b_ready_o  out  1  B ready.
- trans_req_i  in  1  request issued.
- trans_we_i  in  1  1 = write; writes push nothing.
- trans_id_i  in  AXI_ID_WIDTH  ID of the issued request.
- trans_add_i  in  AXI_ADDR_WIDTH  address of the issued request.
- lane_fifo_ovf_o  out  1  sticky overflow flag.
- lane_fifo_udf_o  out  1  sticky underflow flag.

Behaviour:
- Reset:
  - All outputs are 0.
  - Lane FIFOs are empty; sticky flags are cleared.
  - Round-robin pointer favours R.
- Lane index width: LW = log2(AXI_DATA_WIDTH/32); LW = 0 means a single lane, with no FIFO storage and no select.
- Lane push:
  - On trans_req_i && !trans_we_i, push trans_add_i[LW+1:2] into FIFO[trans_id_i].
  - Push to a full FIFO is dropped and sets lane_fifo_ovf_o.
- Arbitration, combinational each cycle:
  - Only R valid: grant R. Only B valid: grant B.
  - Both valid: grant the channel not granted last time; the pointer updates only when both are valid.
  - axi_master_r_ready_o = grant R; axi_master_b_ready_o = grant B.
  - Ready is 0 whenever the matching valid is low, so there is no dependence on the reverse path.
- R handshake:
  - Lane = head of FIFO[r_id].
  - rdata = r_data_i[32*lane +: 32].
  - Pop the FIFO only when r_last_i = 1.
  - If the FIFO is empty: use lane 0 and set lane_fifo_udf_o.
  - Same-cycle push and pop on one ID are both performed; FIFO occupancy is unchanged.
  - A push to a full FIFO that pops in the same cycle succeeds.
- B handshake: rdata = {31'b0, ~b_resp_i[0]}.
- Output register, latency 1 cycle after the handshake:
  - per_slave_r_valid_o = 1.
  - per_slave_r_id_o has bit [id] set.
  - per_slave_r_opc_o = resp[1].
- Cycle without a handshake: valid = 0; id, rdata and opc are 0.
- Back-to-back handshakes produce back-to-back valid pulses, one per cycle.
- Sticky flags clear only on rst_i.
- Reset mid-operation: pending lane entries are discarded; the response in flight is lost.

Optional Feature:
- Macro: PER2AXI_XRESP_EN.
- When defined:
  - On an output cycle whose resp = 2'b10, axi_xresp_slverr_o[id] = 1 and axi_xresp_valid_o[id] = 1.
  - Both are registered and aligned with per_slave_r_valid_o.
- When undefined: both outputs are tied 0 and no logic is generated.

Test Plan:
- Read, AXI_DATA_WIDTH=128: issue a read to address 0x0000_0008 with ID 1; then R with id=1, last=1, data word2=0xCAFE_F00D. Required next cycle: valid=1, id=5'b00010, rdata=0xCAFE_F00D, opc=0.
- Arbitration: R and B held valid for 4 cycles. Required: grants alternate R, B, R, B; 4 output pulses.
- Outstanding reads, NB_OUTSTANDING=2: ID0 reads to addresses 0x4 then 0x0; two R beats follow. Required: upper word, then lower word (64-bit data).
- Full FIFO: push with ID2 and FIFO full. Required: lane_fifo_ovf_o=1 and stays 1. An R with no prior request gives lane_fifo_udf_o=1 and rdata = lane 0.
- Write error with PER2AXI_XRESP_EN defined: B with id=3, resp=2'b10. Required: rdata=1, opc=1, xresp_slverr_o=4'b1000, xresp_valid_o=4'b1000, all in the same cycle.
- Reset check: assert rst_i while R is valid with entries pending. Required: next cycle all outputs are 0 and the FIFOs are empty.
